// File: rtl/idma_stream_tracker_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : idma_stream_tracker_pkg                                      |
// | Description : Shared constants and helpers for the iDMA stream ID tracker. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package idma_stream_tracker_pkg;

    localparam int unsigned MaxNumStreams = 16;

    // A single stream still needs a 1-bit index so port widths never collapse to zero.
    function automatic int unsigned stream_id_width(input int unsigned num_streams);
        return (num_streams > 1) ? $clog2(num_streams) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_v3.sv
// +----------------------------------------------------------------------------+
// | Module      : fifo_v3                                                      |
// | Description : Synchronous FIFO, optional fall-through, power-of-two depth. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    typedef logic [ADDR_DEPTH-1:0] ptr_t;
    typedef logic [ADDR_DEPTH:0]   cnt_t;

    ptr_t                  r_rd_ptr, r_wr_ptr;
    cnt_t                  r_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_push, w_pop;

    assign full_o = (r_count == cnt_t'(DEPTH));

    always_comb begin
        data_o  = r_mem[r_rd_ptr];
        empty_o = (r_count == '0);
        w_push  = push_i & ~full_o;
        w_pop   = pop_i & (r_count != '0);
        // Fall-through bypass: an empty FIFO presents the incoming word directly.
        if (FALL_THROUGH && (r_count == '0) && push_i) begin
            data_o  = data_i;
            empty_o = 1'b0;
            if (pop_i) begin
                w_push = 1'b0;
                w_pop  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            if (w_push && !w_pop)      r_count <= r_count + cnt_t'(1);
            else if (!w_push && w_pop) r_count <= r_count - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/idma_stream_id_tracker.sv
// +----------------------------------------------------------------------------+
// | Module      : idma_stream_id_tracker                                       |
// | Description : Per-stream transfer-ID bookkeeping between front-end and     |
// |               iDMA backend. Optional checks: IDMA_STREAM_TRACKER_CHECK_EN. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module idma_stream_id_tracker
    import idma_stream_tracker_pkg::*;
#(
    parameter int unsigned NumStreams     = 1,
    parameter int unsigned IdCounterWidth = 32,
    parameter int unsigned FifoDepth      = 8,
    parameter int unsigned StreamWidth    = stream_id_width(NumStreams),
    parameter type         dma_req_t      = logic,
    parameter type         stream_t       = logic [StreamWidth-1:0],
    parameter type         cnt_width_t    = logic [IdCounterWidth-1:0]
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  dma_req_t                             req_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [StreamWidth-1:0]               stream_idx_i,
    output logic [IdCounterWidth-1:0]            next_id_o,
    output dma_req_t                             be_req_o,
    output logic                                 be_valid_o,
    input  logic                                 be_ready_i,
    input  logic                                 be_done_i,
    output logic [NumStreams*IdCounterWidth-1:0] done_id_o,
    output logic [NumStreams*IdCounterWidth-1:0] stream_next_id_o,
    output logic [NumStreams-1:0]                busy_o,
    output logic                                 error_o
);

    localparam int unsigned c_OUT_WIDTH = $clog2(FifoDepth + 1);
    typedef logic [c_OUT_WIDTH-1:0] out_cnt_t;

    logic                  w_full, w_empty, w_accept, w_pop, w_in_range;
    stream_t               w_stream_sel, w_head;
    logic [NumStreams-1:0] w_inc, w_dec;
    cnt_width_t            r_next_id     [NumStreams];
    cnt_width_t            r_done_id     [NumStreams];
    out_cnt_t              r_outstanding [NumStreams];

    assign be_req_o    = req_i;
    assign be_valid_o  = req_valid_i & ~w_full;
    assign req_ready_o = be_ready_i & ~w_full;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_pop       = be_done_i & ~w_empty;

    // Out-of-range indices are folded onto stream 0 before they reach the FIFO.
    assign w_in_range   = (32'(stream_idx_i) < NumStreams);
    assign w_stream_sel = w_in_range ? stream_idx_i : stream_t'(0);
    assign next_id_o    = r_next_id[w_stream_sel];

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (StreamWidth),
        .DEPTH        (FifoDepth)
    ) i_issue_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_i  (w_stream_sel),
        .push_i  (w_accept),
        .data_o  (w_head),
        .pop_i   (w_pop)
    );

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int unsigned s = 0; s < NumStreams; s++) begin
            w_inc[s] = w_accept && (w_stream_sel == stream_t'(s));
            w_dec[s] = w_pop && (w_head == stream_t'(s));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < NumStreams; s++) begin
                r_next_id[s]     <= cnt_width_t'(1);
                r_done_id[s]     <= '0;
                r_outstanding[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NumStreams; s++) begin
                if (w_inc[s]) r_next_id[s] <= r_next_id[s] + cnt_width_t'(1);
                if (w_dec[s]) r_done_id[s] <= r_done_id[s] + cnt_width_t'(1);
                if (w_inc[s] && !w_dec[s])      r_outstanding[s] <= r_outstanding[s] + out_cnt_t'(1);
                else if (!w_inc[s] && w_dec[s]) r_outstanding[s] <= r_outstanding[s] - out_cnt_t'(1);
            end
        end
    end

    always_comb begin
        done_id_o        = '0;
        stream_next_id_o = '0;
        busy_o           = '0;
        for (int unsigned s = 0; s < NumStreams; s++) begin
            done_id_o[s*IdCounterWidth +: IdCounterWidth]        = r_done_id[s];
            stream_next_id_o[s*IdCounterWidth +: IdCounterWidth] = r_next_id[s];
            busy_o[s]                                            = (r_outstanding[s] != '0);
        end
    end

`ifdef IDMA_STREAM_TRACKER_CHECK_EN
    logic r_error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_error <= 1'b0;
        else         r_error <= r_error | (be_done_i & w_empty) | (w_accept & ~w_in_range);
    end

    assign error_o = r_error;

    a_done_on_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(be_done_i && w_empty))
        else $warning("be_done_i with no outstanding transfer");
    a_stream_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_accept && !w_in_range))
        else $warning("stream_idx_i out of range on accept");
    a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=> (!req_valid_i || $stable(req_i)))
        else $warning("req_i changed while waiting for ready");
`else
    assign error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idma_stream_id_tracker.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_idma_stream_id_tracker                                    |
// | Description : Self-checking bench with a queue-based reference model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_idma_stream_id_tracker;

`ifdef IDMA_STREAM_TRACKER_CHECK_EN
    localparam logic c_EXP_ERR = 1'b1;
`else
    localparam logic c_EXP_ERR = 1'b0;
`endif
    localparam int c_NS = 4;
    localparam int c_W  = 2;
    localparam int c_MOD = 4;
    localparam int c_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] req = '0;
    logic        req_valid = 1'b0, be_ready = 1'b0, be_done = 1'b0;
    logic [1:0]  stream_idx = '0;
    logic        req_ready_o, be_valid_o, error_o;
    logic [1:0]  next_id_o;
    logic [15:0] be_req_o;
    logic [7:0]  done_id_o, stream_next_id_o;
    logic [3:0]  busy_o;

    // Second instance with three streams so index 3 is out of range.
    logic        r3_valid = 1'b0, r3_done = 1'b0, r3_ready = 1'b1;
    logic [1:0]  r3_idx = '0;
    logic        r3_req_ready, r3_be_valid, r3_error;
    logic [7:0]  r3_next_id;
    logic [15:0] r3_be_req;
    logic [23:0] r3_done_id, r3_stream_next;
    logic [2:0]  r3_busy;

    int n_checks = 0;
    int n_errors = 0;

    int m_next [c_NS];
    int m_done [c_NS];
    int q[$];
    bit cur_v, cur_rdy, cur_done;
    int cur_s;

    always #5 clk = ~clk;

    idma_stream_id_tracker #(
        .NumStreams(c_NS), .IdCounterWidth(c_W), .FifoDepth(c_DEPTH), .dma_req_t(logic [15:0])
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .req_valid_i(req_valid),
        .req_ready_o(req_ready_o), .stream_idx_i(stream_idx), .next_id_o(next_id_o),
        .be_req_o(be_req_o), .be_valid_o(be_valid_o), .be_ready_i(be_ready),
        .be_done_i(be_done), .done_id_o(done_id_o), .stream_next_id_o(stream_next_id_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    idma_stream_id_tracker #(
        .NumStreams(3), .IdCounterWidth(8), .FifoDepth(4), .dma_req_t(logic [15:0])
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .req_valid_i(r3_valid),
        .req_ready_o(r3_req_ready), .stream_idx_i(r3_idx), .next_id_o(r3_next_id),
        .be_req_o(r3_be_req), .be_valid_o(r3_be_valid), .be_ready_i(r3_ready),
        .be_done_i(r3_done), .done_id_o(r3_done_id), .stream_next_id_o(r3_stream_next),
        .busy_o(r3_busy), .error_o(r3_error)
    );

    function automatic bit m_busy(input int s);
        foreach (q[i]) if (q[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply(input bit v, input int s, input bit rdy, input bit done);
        cur_v = v; cur_s = s; cur_rdy = rdy; cur_done = done;
        req_valid = v; stream_idx = 2'(s); be_ready = rdy; be_done = done;
        req = 16'($urandom);
        #1;
    endtask

    task automatic tick();
        bit acc, pop;
        int h;
        acc = cur_v && cur_rdy && (q.size() < c_DEPTH);
        pop = cur_done && (q.size() != 0);
        @(posedge clk);
        if (pop) begin
            h = q.pop_front();
            m_done[h] = (m_done[h] + 1) % c_MOD;
        end
        if (acc) begin
            q.push_back(cur_s);
            m_next[cur_s] = (m_next[cur_s] + 1) % c_MOD;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid = 1'b0; be_ready = 1'b0; be_done = 1'b0; stream_idx = '0;
        cur_v = 0; cur_rdy = 0; cur_done = 0; cur_s = 0;
        r3_valid = 1'b0; r3_done = 1'b0; r3_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int s = 0; s < c_NS; s++) begin
            m_next[s] = 1;
            m_done[s] = 0;
        end
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        apply(1, 0, 1, 0);
        for (int s = 0; s < c_NS; s++) begin
            n_checks++;
            if (stream_next_id_o[s*c_W +: c_W] !== 2'd1 || done_id_o[s*c_W +: c_W] !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_ids s%0d: next=%0d done=%0d expected 1/0", s,
                         stream_next_id_o[s*c_W +: c_W], done_id_o[s*c_W +: c_W]);
            end
        end
        n_checks++;
        if (busy_o !== 4'b0 || error_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%b error=%b expected 0000/0", busy_o, error_o);
        end
        n_checks++;
        if (be_valid_o !== 1'b1 || req_ready_o !== 1'b1 || be_req_o !== req) begin
            n_errors++;
            $display("FAIL reset_issue: valid=%b ready=%b be_req=%h expected 1/1/%h",
                     be_valid_o, req_ready_o, be_req_o, req);
        end
        apply(0, 0, 1, 0);
        n_checks++;
        if (be_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid_follow: valid=%b expected 0", be_valid_o);
        end
    endtask

    task automatic test_single_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1, 2, 1, 0);
            n_checks++;
            if (next_id_o !== 2'(i + 1)) begin
                n_errors++;
                $display("FAIL single_next_id[%0d]: got %0d expected %0d", i, next_id_o, i + 1);
            end
            tick();
        end
        n_checks++;
        if (busy_o !== 4'b0100) begin
            n_errors++;
            $display("FAIL single_busy: got %b expected 0100", busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 1);
            tick();
        end
        n_checks++;
        if (done_id_o[2*c_W +: c_W] !== 2'd3 || busy_o[2] !== 1'b0 || stream_next_id_o[2*c_W +: c_W] !== 2'd0) begin
            n_errors++;
            $display("FAIL single_done: done=%0d busy=%b next=%0d expected 3/0/0",
                     done_id_o[2*c_W +: c_W], busy_o[2], stream_next_id_o[2*c_W +: c_W]);
        end
    endtask

    task automatic test_interleave();
        int seq [4];
        int d0 [4];
        int d1 [4];
        seq = '{0, 1, 0, 1};
        d0  = '{1, 1, 2, 2};
        d1  = '{0, 1, 1, 2};
        do_reset();
        foreach (seq[i]) begin
            apply(1, seq[i], 1, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 1);
            tick();
            n_checks++;
            if (done_id_o[0 +: c_W] !== 2'(d0[i]) || done_id_o[c_W +: c_W] !== 2'(d1[i])) begin
                n_errors++;
                $display("FAIL interleave_done[%0d]: got %0d/%0d expected %0d/%0d", i,
                         done_id_o[0 +: c_W], done_id_o[c_W +: c_W], d0[i], d1[i]);
            end
        end
        n_checks++;
        if (busy_o !== 4'b0) begin
            n_errors++;
            $display("FAIL interleave_busy: got %b expected 0000", busy_o);
        end
    endtask

    task automatic test_full();
        int s;
        do_reset();
        for (int i = 0; i < c_DEPTH; i++) begin
            apply(1, $urandom_range(0, 3), 1, 0);
            tick();
        end
        s = $urandom_range(0, 3);
        apply(1, s, 1, 1);
        n_checks++;
        if (req_ready_o !== 1'b0 || be_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL full_block: ready=%b valid=%b expected 0/0", req_ready_o, be_valid_o);
        end
        tick();
        apply(1, s, 1, 0);
        n_checks++;
        if (req_ready_o !== 1'b1 || be_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL full_resume: ready=%b valid=%b expected 1/1", req_ready_o, be_valid_o);
        end
        tick();
        for (int k = 0; k < c_NS; k++) begin
            n_checks++;
            if (stream_next_id_o[k*c_W +: c_W] !== 2'(m_next[k]) || done_id_o[k*c_W +: c_W] !== 2'(m_done[k])
                || busy_o[k] !== m_busy(k)) begin
                n_errors++;
                $display("FAIL full_state s%0d: next=%0d done=%0d busy=%b expected %0d/%0d/%b", k,
                         stream_next_id_o[k*c_W +: c_W], done_id_o[k*c_W +: c_W], busy_o[k],
                         m_next[k], m_done[k], m_busy(k));
            end
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        apply(1, 1, 1, 0);
        tick();
        apply(1, 1, 1, 1);
        tick();
        n_checks++;
        if (busy_o[1] !== 1'b1 || stream_next_id_o[c_W +: c_W] !== 2'd3 || done_id_o[c_W +: c_W] !== 2'd1) begin
            n_errors++;
            $display("FAIL same_cycle: busy=%b next=%0d done=%0d expected 1/3/1", busy_o[1],
                     stream_next_id_o[c_W +: c_W], done_id_o[c_W +: c_W]);
        end
    endtask

    task automatic test_wrap();
        int nseq [6];
        int dseq [6];
        nseq = '{1, 2, 3, 0, 1, 2};
        dseq = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1, 3, 1, 0);
            n_checks++;
            if (next_id_o !== 2'(nseq[i])) begin
                n_errors++;
                $display("FAIL wrap_issue_id[%0d]: got %0d expected %0d", i, next_id_o, nseq[i]);
            end
            tick();
            apply(0, 0, 1, 1);
            tick();
            n_checks++;
            if (stream_next_id_o[3*c_W +: c_W] !== 2'(nseq[i+1]) || done_id_o[3*c_W +: c_W] !== 2'(dseq[i+1])) begin
                n_errors++;
                $display("FAIL wrap_ids[%0d]: next=%0d done=%0d expected %0d/%0d", i,
                         stream_next_id_o[3*c_W +: c_W], done_id_o[3*c_W +: c_W], nseq[i+1], dseq[i+1]);
            end
        end
    endtask

    task automatic test_empty_done();
        do_reset();
        apply(0, 0, 1, 1);
        tick();
        n_checks++;
        if (done_id_o !== 8'h00 || busy_o !== 4'b0 || error_o !== c_EXP_ERR) begin
            n_errors++;
            $display("FAIL empty_done: done=%h busy=%b error=%b expected 00/0000/%b",
                     done_id_o, busy_o, error_o, c_EXP_ERR);
        end
        apply(1, 2, 1, 1);
        tick();
        n_checks++;
        if (busy_o !== 4'b0100 || done_id_o[2*c_W +: c_W] !== 2'd0 || stream_next_id_o[2*c_W +: c_W] !== 2'd2) begin
            n_errors++;
            $display("FAIL empty_done_push: busy=%b done=%0d next=%0d expected 0100/0/2",
                     busy_o, done_id_o[2*c_W +: c_W], stream_next_id_o[2*c_W +: c_W]);
        end
        apply(0, 0, 1, 0);
        tick();
        n_checks++;
        if (error_o !== c_EXP_ERR) begin
            n_errors++;
            $display("FAIL error_sticky: got %b expected %b", error_o, c_EXP_ERR);
        end
    endtask

    task automatic test_random();
        bit v, rdy, dn;
        int s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            dn  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            s   = $urandom_range(0, 3);
            apply(v, s, rdy, dn);
            n_checks++;
            if (req_ready_o !== (rdy && q.size() < c_DEPTH) || be_valid_o !== (v && q.size() < c_DEPTH)
                || be_req_o !== req || next_id_o !== 2'(m_next[s])) begin
                n_errors++;
                $display("FAIL random_issue[%0d]: ready=%b valid=%b next=%0d expected %b/%b/%0d", i,
                         req_ready_o, be_valid_o, next_id_o, rdy && q.size() < c_DEPTH,
                         v && q.size() < c_DEPTH, m_next[s]);
            end
            tick();
            for (int k = 0; k < c_NS; k++) begin
                n_checks++;
                if (stream_next_id_o[k*c_W +: c_W] !== 2'(m_next[k]) || done_id_o[k*c_W +: c_W] !== 2'(m_done[k])
                    || busy_o[k] !== m_busy(k)) begin
                    n_errors++;
                    $display("FAIL random_state[%0d] s%0d: next=%0d done=%0d busy=%b expected %0d/%0d/%b",
                             i, k, stream_next_id_o[k*c_W +: c_W], done_id_o[k*c_W +: c_W], busy_o[k],
                             m_next[k], m_done[k], m_busy(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1, $urandom_range(0, 3), 1, 0);
            tick();
        end
        apply(0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 4'b0 || stream_next_id_o !== 8'b01010101 || done_id_o !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid: busy=%b next=%h done=%h expected 0000/55/00",
                     busy_o, stream_next_id_o, done_id_o);
        end
        do_reset();
    endtask

    task automatic test_out_of_range();
        do_reset();
        r3_valid = 1'b1; r3_idx = 2'd3;
        #1;
        n_checks++;
        if (r3_next_id !== 8'd1 || r3_req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_issue: next=%0d ready=%b expected 1/1", r3_next_id, r3_req_ready);
        end
        @(posedge clk);
        #1;
        r3_valid = 1'b0;
        n_checks++;
        if (r3_stream_next !== {8'd1, 8'd1, 8'd2} || r3_busy !== 3'b001) begin
            n_errors++;
            $display("FAIL oor_route: next=%h busy=%b expected 010102/001", r3_stream_next, r3_busy);
        end
        r3_done = 1'b1;
        @(posedge clk);
        #1;
        r3_done = 1'b0;
        n_checks++;
        if (r3_done_id !== {8'd0, 8'd0, 8'd1} || r3_busy !== 3'b000 || r3_error !== c_EXP_ERR) begin
            n_errors++;
            $display("FAIL oor_done: done=%h busy=%b error=%b expected 000001/000/%b",
                     r3_done_id, r3_busy, r3_error, c_EXP_ERR);
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_interleave();
        test_full();
        test_same_cycle();
        test_wrap();
        test_empty_done();
        test_random();
        test_reset_mid();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
